// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - pipeline and RAM side signal bundle for the memory controller
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_inst;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_size;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    // controller side
    modport slave (
        input  if_req, if_addr, if_flush,
        output if_done, if_inst,
        input  mem_req, mem_we, mem_addr, mem_size, mem_wdata,
        output mem_done, mem_rdata,
        output ram_a, ram_wr, ram_dout,
        input  ram_din
    );

    // pipeline stages and RAM side
    modport master (
        output if_req, if_addr, if_flush,
        input  if_done, if_inst,
        output mem_req, mem_we, mem_addr, mem_size, mem_wdata,
        input  mem_done, mem_rdata,
        input  ram_a, ram_wr, ram_dout,
        output ram_din
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM controller arbitrating instruction fetch and data access
module mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        IF_RD       = 3'd1,
        MEM_RD      = 3'd2,
        MEM_WR      = 3'd3,
        FLUSH_DRAIN = 3'd4
    } state_t;

    // read beats arrive LAT cycles after their address
    localparam logic [2:0] LAT = 3'(RAM_LAT);

    state_t            state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    logic [2:0]        len, len_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [31:0]       wdata, wdata_nx;
    logic [31:0]       rbuf, rbuf_nx;
    logic              if_done_q, if_done_nx;
    logic              mem_done_q, mem_done_nx;
    logic [31:0]       if_inst_q, if_inst_nx;
    logic [31:0]       mem_rdata_q, mem_rdata_nx;
    logic [ADDR_W-1:0] ram_a_c;
    logic              ram_wr_c;
    logic [7:0]        ram_dout_c;
    logic [1:0]        lane;

    // byte lane receiving the beat returning this cycle
    assign lane = 2'(cnt - LAT);

    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // next-state, datapath updates and RAM port drive
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        len_nx       = len;
        addr_nx      = addr;
        wdata_nx     = wdata;
        rbuf_nx      = rbuf;
        if_done_nx   = 1'b0;
        mem_done_nx  = 1'b0;
        if_inst_nx   = if_inst_q;
        mem_rdata_nx = mem_rdata_q;
        ram_a_c      = '0;
        ram_wr_c     = 1'b0;
        ram_dout_c   = 8'h00;
        case (state)
            IDLE: begin
                // the done cycle is a bubble so requesters can move address/pc
                if (!if_done_q && !mem_done_q) begin
                    if (bus.mem_req) begin
                        state_nx = bus.mem_we ? MEM_WR : MEM_RD;
                        addr_nx  = bus.mem_addr;
                        len_nx   = size_len(bus.mem_size);
                        wdata_nx = bus.mem_wdata;
                        cnt_nx   = 3'd0;
                        rbuf_nx  = 32'h0;
                    end else if (bus.if_req && !bus.if_flush) begin
                        state_nx = IF_RD;
                        addr_nx  = bus.if_addr;
                        len_nx   = 3'd4;
                        cnt_nx   = 3'd0;
                        rbuf_nx  = 32'h0;
                    end
                end
            end
            IF_RD, MEM_RD: begin
                if (cnt >= LAT) begin
                    rbuf_nx[{lane, 3'b000} +: 8] = bus.ram_din;
                end
                if (state == IF_RD && bus.if_flush) begin
                    state_nx = FLUSH_DRAIN;
                    cnt_nx   = 3'd0;
                end else begin
                    if (cnt < len) begin
                        ram_a_c = addr + ADDR_W'(cnt);
                    end
                    if (cnt == len + LAT - 3'd1) begin
                        state_nx = IDLE;
                        if (state == IF_RD) begin
                            if_done_nx = 1'b1;
                            if_inst_nx = rbuf_nx;
                        end else begin
                            mem_done_nx  = 1'b1;
                            mem_rdata_nx = rbuf_nx;
                        end
                    end else begin
                        cnt_nx = cnt + 3'd1;
                    end
                end
            end
            MEM_WR: begin
                ram_a_c    = addr + ADDR_W'(cnt);
                ram_wr_c   = 1'b1;
                ram_dout_c = wdata[{cnt[1:0], 3'b000} +: 8];
                if (cnt == len - 3'd1) begin
                    state_nx    = IDLE;
                    mem_done_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            FLUSH_DRAIN: begin
                // the beat for the last issued address lands here and is dropped
                state_nx = IDLE;
                cnt_nx   = 3'd0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            len         <= 3'd0;
            addr        <= '0;
            wdata       <= 32'h0;
            rbuf        <= 32'h0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            len         <= len_nx;
            addr        <= addr_nx;
            wdata       <= wdata_nx;
            rbuf        <= rbuf_nx;
            if_done_q   <= if_done_nx;
            mem_done_q  <= mem_done_nx;
            if_inst_q   <= if_inst_nx;
            mem_rdata_q <= mem_rdata_nx;
        end
    end

    assign bus.if_done   = if_done_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.ram_a     = ram_a_c;
    assign bus.ram_wr    = ram_wr_c;
    assign bus.ram_dout  = ram_dout_c;
endmodule
